// File: rtl/epsilon_stream_gen.sv
// rtl/epsilon_stream_gen.sv - serial epsilon-bit stimulus source and verdict collector
// Shifts a SEQ_LEN-bit block into a randomness-test core, then latches its verdict and run statistics.
module epsilon_stream_gen #(
  parameter int          SEQ_LEN = 128,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       epsilon_rsc_dat,
  output logic       epsilon_vld,
  input  logic       is_random_rsc_dat,
  input  logic       valid_rsc_dat,
  output logic       busy,
  output logic       done,
  output logic       result,
  output logic       timeout,
  output logic [7:0] run_cnt,
  output logic [7:0] pass_cnt
);
  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, REPORT} state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [15:0]    idx_q, idx_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [15:0]    lfsr_q, lfsr_d, lfsr_next;
  logic           dat_q, dat_d, vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic           result_q, result_d, timeout_q, timeout_d;
  logic [7:0]     run_q, run_d, pass_q, pass_d;
  logic [1:0]     m_sel;
  logic           i0_sel, bit_sel, go_report;

  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // Bit 0 is produced on the IDLE->SEND edge, so the source must look at the live mode there.
  assign m_sel  = (state_q == IDLE) ? mode : mode_q;
  assign i0_sel = (state_q == IDLE) ? 1'b0 : idx_q[0];

  always_comb begin
    bit_sel = 1'b0;
    case (m_sel)
      2'b00:   bit_sel = lfsr_q[0];
      2'b01:   bit_sel = 1'b0;
      2'b10:   bit_sel = i0_sel;
      default: bit_sel = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    lfsr_d    = lfsr_q;
    dat_d     = 1'b0;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    result_d  = result_q;
    timeout_d = timeout_q;
    run_d     = run_q;
    pass_d    = pass_q;
    go_report = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          mode_d  = mode;
          vld_d   = 1'b1;
          dat_d   = bit_sel;
          idx_d   = 16'd1;
          if (mode == 2'b00) lfsr_d = lfsr_next;
        end
      end
      SEND: begin
        if (idx_q == 16'(SEQ_LEN)) begin
          state_d = WAIT;
          wcnt_d  = '0;
        end else begin
          vld_d = 1'b1;
          dat_d = bit_sel;
          idx_d = idx_q + 16'd1;
          if (mode_q == 2'b00) lfsr_d = lfsr_next;
        end
      end
      WAIT: begin
        if (valid_rsc_dat) begin
          result_d  = is_random_rsc_dat;
          timeout_d = 1'b0;
          go_report = 1'b1;
        end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
          result_d  = 1'b0;
          timeout_d = 1'b1;
          go_report = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters update on entry to REPORT so they are visible together with done.
    if (go_report) begin
      state_d = REPORT;
      done_d  = 1'b1;
      if (run_q != 8'hFF) run_d = run_q + 8'd1;
      if (result_d && pass_q != 8'hFF) pass_d = pass_q + 8'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      idx_q     <= '0;
      wcnt_q    <= '0;
      lfsr_q    <= SEED;
      dat_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 1'b0;
      timeout_q <= 1'b0;
      run_q     <= '0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      lfsr_q    <= lfsr_d;
      dat_q     <= dat_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      run_q     <= run_d;
      pass_q    <= pass_d;
    end
  end

  assign epsilon_rsc_dat = dat_q;
  assign epsilon_vld     = vld_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;
  assign timeout         = timeout_q;
  assign run_cnt         = run_q;
  assign pass_cnt        = pass_q;
endmodule

// File: doc/epsilon_stream_gen.md
Name: epsilon_stream_gen

Overview:
- Stimulus transmitter for the randomness-test cores (approximate-entropy / random-excursions family).
- On a start request, serially drives a block of SEQ_LEN epsilon bits into a test core's epsilon_rsc_dat input, one bit per clock. Bits come from a selectable source.
- Then waits for the core's valid_rsc_dat/is_random_rsc_dat verdict, latches it, and keeps run/pass statistics.
- Sits between the top-level pins and the test core; the other end of the epsilon/verdict interface.

Parameters:
- SEQ_LEN, 128: bits transmitted per run (legal 2..65535).
- SEED, 16'hACE1: LFSR reset value; must be non-zero.
- TIMEOUT, 1024: maximum cycles spent in WAIT before a run is abandoned.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled request; acted on only in IDLE.
- mode  in  2  bit source: 00 LFSR, 01 all zeros, 10 alternating (0,1,0,1...), 11 all ones. Latched at start.
- epsilon_rsc_dat  out  1  serial bit to the test core.
- epsilon_vld  out  1  high while epsilon_rsc_dat carries a block bit.
- is_random_rsc_dat  in  1  verdict from the test core.
- valid_rsc_dat  in  1  verdict qualifier from the test core.
- busy  out  1  high in SEND, WAIT and REPORT.
- done  out  1  one-cycle pulse when a run completes.
- result  out  1  latched verdict of the last run (1 = random).
- timeout  out  1  latched: last run ended by timeout.
- run_cnt  out  8  completed runs; saturates at 255.
- pass_cnt  out  8  runs with result=1; saturates at 255.

Behaviour:
- Reset (async assert, sync release):
  - FSM returns to IDLE; LFSR is loaded with SEED.
  - Bit counter and wait counter clear.
  - All outputs are 0.
  - Reset mid-run abandons the run with no counter update.
- All outputs are registered.
- FSM states: IDLE, SEND, WAIT, REPORT.
- IDLE:
  - If start=1 at edge T, latch mode, clear the bit index, and enter SEND at T.
  - The first bit is valid in the cycle after T (1-cycle latency).
- SEND:
  - Each cycle drive epsilon_vld=1 and epsilon_rsc_dat = the source bit for index i (i = 0..SEQ_LEN-1).
  - After bit SEQ_LEN-1 has been driven, enter WAIT.
  - epsilon_vld is high for exactly SEQ_LEN consecutive cycles.
- Bit sources:
  - LFSR: bit = lfsr[0]; next = {lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5], lfsr[15:1]}.
  - The LFSR advances only on SEND cycles in LFSR mode. It is NOT reseeded between runs, so consecutive runs continue the sequence.
  - Alternating: bit = i[0], so bit 0 is 0.
  - Zeros/ones: constant.
- WAIT:
  - epsilon_vld=0, epsilon_rsc_dat=0.
  - Wait counter increments each cycle.
  - valid_rsc_dat=1 captures is_random_rsc_dat into result, sets timeout=0, and enters REPORT.
  - Wait counter reaching TIMEOUT-1 with no valid sets result=0, timeout=1, and enters REPORT.
  - If valid arrives on that same cycle, valid wins.
  - valid_rsc_dat is ignored in every state other than WAIT.
- REPORT:
  - done=1 for one cycle.
  - run_cnt increments.
  - pass_cnt increments if result=1.
  - Both counters saturate at 255.
  - Returns to IDLE.
  - A start held high continuously re-triggers on the first IDLE cycle, giving back-to-back runs with one IDLE cycle between them.
- start is ignored while busy=1. mode changes during a run have no effect.

Test Plan:
- Reset, mode=00, start pulse, SEQ_LEN=128 -> epsilon_vld high for 128 cycles starting 1 cycle after start; first five bits 1,0,0,0,0; busy=1 throughout.
- mode=10, core asserts valid=1 with is_random=1 on cycle 3 of WAIT -> stream 0,1,0,1...; done pulses once; result=1; timeout=0; run_cnt=1; pass_cnt=1.
- mode=01, valid never asserted -> after 1024 WAIT cycles: done pulses, result=0, timeout=1, run_cnt increments, pass_cnt unchanged.
- Two LFSR runs back-to-back with start held high -> run 2's first bit equals the LFSR bit at index 128 of a continuous sequence from SEED (no reseed); exactly one IDLE cycle between runs.
- rst_n low at bit 60 of SEND -> all outputs 0 immediately; after release the next run restarts from SEED with counters at 0. Also: start pulses and valid pulses during SEND are ignored.
- 260 passing runs -> run_cnt=255 and pass_cnt=255 (saturated, no wrap).
